acq_search_ctrl: RTL and testbench
==================================

Name: acq_search_ctrl

Overview:
Sequencer for the acquisition engine: sweeps enabled satellites (PRNs) across all Doppler bins, one engine run per (PRN, bin). Keeps the best correlation peak per PRN, compares it with a threshold, and builds the detected-satellite bitmask. Sits between the host/config logic and the acquisition correlator; the correlator sees only a start/done handshake per bin.

Parameters:
NUM_SAT, 32, number of PRNs searched; bit i of masks = PRN i+1
NUM_BINS, 21, Doppler bins per PRN, indexed 0..NUM_BINS-1
PEAK_W, 32, correlation peak width (unsigned)
PHASE_W, 11, code-phase width
TIMEOUT, 65535, max cycles waiting for eng_done per bin

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  begin a search; honoured only when busy=0
abort  in  1  terminate search; returns to IDLE
sat_mask  in  NUM_SAT  1 = search this PRN; sampled on accepted start
threshold  in  PEAK_W  detection threshold; sampled on accepted start
busy  out  1  search in progress
done  out  1  one-cycle pulse, search complete
timeout_err  out  1  sticky, set if any bin timed out; cleared on accepted start
detected_sat  out  NUM_SAT  bit i set when PRN i+1 detected; cleared on accepted start
eng_start  out  1  one-cycle pulse launching one engine run
eng_prn  out  5  PRN index (0-based) for current run
eng_bin  out  $clog2(NUM_BINS)  Doppler bin for current run
eng_done  in  1  engine result valid (one-cycle pulse)
eng_peak  in  PEAK_W  peak magnitude of completed run
eng_phase  in  PHASE_W  code phase of that peak
res_valid  out  1  one-cycle pulse per detected PRN
res_prn  out  5  detected PRN index
res_bin  out  $clog2(NUM_BINS)  bin of best peak
res_phase  out  PHASE_W  code phase of best peak
res_peak  out  PEAK_W  best peak value

Behaviour:
- Reset: state IDLE; busy, done, eng_start, res_valid, timeout_err = 0; detected_sat, eng_prn, eng_bin, res_* = 0.
- States: IDLE, SELECT, LAUNCH, WAIT, EVAL, REPORT, FINISH.
- IDLE: start=1 at edge N -> latch sat_mask/threshold, clear detected_sat and timeout_err, prn=0, state SELECT; busy=1 from N+1.
- SELECT: one PRN per cycle. If mask bit set: bin=0, best_peak=0, best_bin=0, best_phase=0 -> LAUNCH. Else if prn=NUM_SAT-1 -> FINISH, else prn+1, stay.
- LAUNCH: eng_start=1 for exactly this cycle; clear timeout counter -> WAIT. eng_prn/eng_bin hold from LAUNCH until the run ends.
- WAIT: counter increments each cycle. eng_done=1 -> EVAL and capture eng_peak/eng_phase. Counter reaches TIMEOUT without eng_done -> set timeout_err, treat bin as peak 0, go to EVAL. eng_done outside WAIT is ignored.
- EVAL: if captured peak > best_peak (strict), update best_peak/best_bin/best_phase; on ties the earliest bin wins.
  - If bin<NUM_BINS-1: bin+1 -> LAUNCH.
  - Else if best_peak >= threshold: set detected_sat[prn] -> REPORT.
  - Else advance PRN as SELECT does: go to FINISH if prn=NUM_SAT-1, else prn+1 -> SELECT.
- REPORT: res_valid=1 for one cycle with res_prn/bin/phase/peak = best values. res_* hold until the next REPORT. Then advance PRN as in EVAL.
- FINISH: done=1 for one cycle; busy=0 in that same cycle -> IDLE.
- detected_sat and timeout_err hold until the next accepted start.
- start while busy: ignored.
- abort: highest priority, checked in any busy state. Next state IDLE, busy=0 next cycle. No done, eng_start or res_valid is issued in that cycle. detected_sat keeps partial results. A late eng_done is ignored.
- start and abort together in IDLE: abort wins, start is dropped.
- sat_mask all zero: done pulses NUM_SAT+1 cycles after start; no eng_start is issued.
- Engine runs per search = popcount(sat_mask) x NUM_BINS.

Test Plan:
(Tests use NUM_SAT=4, NUM_BINS=3, TIMEOUT=20.)
- Full sweep: sat_mask=4'b0101, threshold=100; engine returns peaks {50,120,90} for PRN0 and {10,20,30} for PRN2 -> 6 eng_start pulses; one res_valid (prn=0, bin=1, peak=120); detected_sat=4'b0001; done pulses once.
- Tie and threshold-equal: peaks {100,100,40}, threshold=100 -> detected, res_bin=0 (first wins), res_peak=100.
- Timeout: engine silent on PRN1 bin 2 -> timeout_err=1 after 20 WAIT cycles; sweep continues and done still pulses.
- Empty mask: sat_mask=0 -> no eng_start; done exactly 5 cycles after the start edge; busy high for 4 cycles.
- Abort mid-WAIT: then a late eng_done -> busy=0 the next cycle, no done, no res_valid, detected_sat keeps earlier bits; a new start is accepted and clears them.
- Start while busy, plus reset mid-search: start is ignored with no state change; reset forces all outputs to zero on the next edge.

Source files
------------

// File: rtl/acq_search_ctrl.sv
// acq_search_ctrl: sweeps enabled PRNs over all Doppler bins, tracks best peak per PRN and flags detections.
module acq_search_ctrl #(
   parameter int NUM_SAT  = 32,
   parameter int NUM_BINS = 21,
   parameter int PEAK_W   = 32,
   parameter int PHASE_W  = 11,
   parameter int TIMEOUT  = 65535
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        start_i,
   input  logic                        abort_i,
   input  logic [NUM_SAT-1:0]          sat_mask_i,
   input  logic [PEAK_W-1:0]           threshold_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        timeout_err_o,
   output logic [NUM_SAT-1:0]          detected_sat_o,
   output logic                        eng_start_o,
   output logic [4:0]                  eng_prn_o,
   output logic [$clog2(NUM_BINS)-1:0] eng_bin_o,
   input  logic                        eng_done_i,
   input  logic [PEAK_W-1:0]           eng_peak_i,
   input  logic [PHASE_W-1:0]          eng_phase_i,
   output logic                        res_valid_o,
   output logic [4:0]                  res_prn_o,
   output logic [$clog2(NUM_BINS)-1:0] res_bin_o,
   output logic [PHASE_W-1:0]          res_phase_o,
   output logic [PEAK_W-1:0]           res_peak_o
);
   localparam int BW = $clog2(NUM_BINS);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, SELECT, LAUNCH, WAIT, EVAL, REPORT, FINISH} state_t;
   state_t               state_q, state_d;
   logic [4:0]           prn_q, prn_d, res_prn_q, res_prn_d;
   logic [BW-1:0]        bin_q, bin_d, best_bin_q, best_bin_d, res_bin_q, res_bin_d, nb_bin;
   logic [NUM_SAT-1:0]   mask_q, mask_d, det_q, det_d, prn_oh;
   logic [PEAK_W-1:0]    thr_q, thr_d, pk_q, pk_d, best_pk_q, best_pk_d, res_pk_q, res_pk_d, nb_pk;
   logic [PHASE_W-1:0]   ph_q, ph_d, best_ph_q, best_ph_d, res_ph_q, res_ph_d, nb_ph;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 terr_q, terr_d, prn_last, bin_last, upd;
   assign prn_oh   = NUM_SAT'(1) << prn_q;
   assign prn_last = prn_q == 5'(NUM_SAT - 1);
   assign bin_last = bin_q == BW'(NUM_BINS - 1);
   // strict compare keeps the earliest bin on equal peaks
   assign upd      = pk_q > best_pk_q;
   assign nb_pk    = upd ? pk_q : best_pk_q;
   assign nb_bin   = upd ? bin_q : best_bin_q;
   assign nb_ph    = upd ? ph_q : best_ph_q;
   assign busy_o         = state_q != IDLE && state_q != FINISH;
   assign done_o         = state_q == FINISH;
   assign eng_start_o    = state_q == LAUNCH && !abort_i;
   assign res_valid_o    = state_q == REPORT && !abort_i;
   assign timeout_err_o  = terr_q;
   assign detected_sat_o = det_q;
   assign eng_prn_o      = prn_q;
   assign eng_bin_o      = bin_q;
   assign res_prn_o      = res_prn_q;
   assign res_bin_o      = res_bin_q;
   assign res_phase_o    = res_ph_q;
   assign res_peak_o     = res_pk_q;
   always_comb begin
      state_d    = state_q;
      prn_d      = prn_q;
      bin_d      = bin_q;
      mask_d     = mask_q;
      thr_d      = thr_q;
      det_d      = det_q;
      terr_d     = terr_q;
      cnt_d      = cnt_q;
      pk_d       = pk_q;
      ph_d       = ph_q;
      best_pk_d  = best_pk_q;
      best_bin_d = best_bin_q;
      best_ph_d  = best_ph_q;
      res_prn_d  = res_prn_q;
      res_bin_d  = res_bin_q;
      res_ph_d   = res_ph_q;
      res_pk_d   = res_pk_q;
      if (abort_i && busy_o) state_d = IDLE;
      else case (state_q)
         IDLE: if (start_i && !abort_i) begin
            mask_d  = sat_mask_i;
            thr_d   = threshold_i;
            det_d   = '0;
            terr_d  = 1'b0;
            prn_d   = '0;
            state_d = SELECT;
         end
         SELECT: if (|(mask_q & prn_oh)) begin
            bin_d      = '0;
            best_pk_d  = '0;
            best_bin_d = '0;
            best_ph_d  = '0;
            state_d    = LAUNCH;
         end else begin
            state_d = prn_last ? FINISH : SELECT;
            prn_d   = prn_last ? prn_q : prn_q + 5'd1;
         end
         LAUNCH: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: if (eng_done_i) begin
            pk_d    = eng_peak_i;
            ph_d    = eng_phase_i;
            state_d = EVAL;
         end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            terr_d  = 1'b1;
            pk_d    = '0;
            ph_d    = '0;
            state_d = EVAL;
         end else cnt_d = cnt_q + CW'(1);
         EVAL: begin
            best_pk_d  = nb_pk;
            best_bin_d = nb_bin;
            best_ph_d  = nb_ph;
            if (!bin_last) begin
               bin_d   = bin_q + BW'(1);
               state_d = LAUNCH;
            end else if (nb_pk >= thr_q) begin
               det_d     = det_q | prn_oh;
               res_prn_d = prn_q;
               res_bin_d = nb_bin;
               res_ph_d  = nb_ph;
               res_pk_d  = nb_pk;
               state_d   = REPORT;
            end else begin
               state_d = prn_last ? FINISH : SELECT;
               prn_d   = prn_last ? prn_q : prn_q + 5'd1;
            end
         end
         REPORT: begin
            state_d = prn_last ? FINISH : SELECT;
            prn_d   = prn_last ? prn_q : prn_q + 5'd1;
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         prn_q      <= '0;
         bin_q      <= '0;
         mask_q     <= '0;
         thr_q      <= '0;
         det_q      <= '0;
         terr_q     <= 1'b0;
         cnt_q      <= '0;
         pk_q       <= '0;
         ph_q       <= '0;
         best_pk_q  <= '0;
         best_bin_q <= '0;
         best_ph_q  <= '0;
         res_prn_q  <= '0;
         res_bin_q  <= '0;
         res_ph_q   <= '0;
         res_pk_q   <= '0;
      end else begin
         state_q    <= state_d;
         prn_q      <= prn_d;
         bin_q      <= bin_d;
         mask_q     <= mask_d;
         thr_q      <= thr_d;
         det_q      <= det_d;
         terr_q     <= terr_d;
         cnt_q      <= cnt_d;
         pk_q       <= pk_d;
         ph_q       <= ph_d;
         best_pk_q  <= best_pk_d;
         best_bin_q <= best_bin_d;
         best_ph_q  <= best_ph_d;
         res_prn_q  <= res_prn_d;
         res_bin_q  <= res_bin_d;
         res_ph_q   <= res_ph_d;
         res_pk_q   <= res_pk_d;
      end
   end
endmodule

// File: tb/tb_acq_search_ctrl.sv
// tb_acq_search_ctrl: directed sweeps against a small engine model with a queue of expected reports.
module tb_acq_search_ctrl;
   logic        clk = 1'b0;
   logic        reset, start, abort;
   logic [3:0]  sat_mask, detected_sat;
   logic [31:0] threshold, eng_peak, res_peak;
   logic        busy, done, timeout_err, eng_start, eng_done, res_valid;
   logic [4:0]  eng_prn, res_prn;
   logic [1:0]  eng_bin, res_bin;
   logic [10:0] eng_phase, res_phase;
   typedef struct packed {
      logic [4:0]  prn;
      logic [1:0]  bin;
      logic [10:0] ph;
      logic [31:0] pk;
   } res_t;
   res_t        exp_q[$];
   res_t        got;
   logic [31:0] tbl [4][3];
   logic        silent [4][3];
   int          lat [4];
   int passed = 0, total = 0, fails = 0;
   int n_start = 0, n_done = 0, n_res = 0;
   int s0, d0, r0;
   always #5 clk = ~clk;
   acq_search_ctrl #(.NUM_SAT(4), .NUM_BINS(3), .PEAK_W(32), .PHASE_W(11), .TIMEOUT(20)) dut (
      .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
      .sat_mask_i(sat_mask), .threshold_i(threshold),
      .busy_o(busy), .done_o(done), .timeout_err_o(timeout_err), .detected_sat_o(detected_sat),
      .eng_start_o(eng_start), .eng_prn_o(eng_prn), .eng_bin_o(eng_bin),
      .eng_done_i(eng_done), .eng_peak_i(eng_peak), .eng_phase_i(eng_phase),
      .res_valid_o(res_valid), .res_prn_o(res_prn), .res_bin_o(res_bin),
      .res_phase_o(res_phase), .res_peak_o(res_peak)
   );
   function automatic logic [10:0] ph(input int p, input int b);
      return 11'(100 + 10 * p + b);
   endfunction
   function automatic res_t mk(input int p, input int b, input logic [31:0] pk);
      return '{prn: 5'(p), bin: 2'(b), ph: ph(p, b), pk: pk};
   endfunction
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic do_start(input logic [3:0] m, input logic [31:0] t);
      start = 1'b1;
      sat_mask = m;
      threshold = t;
      @(negedge clk);
      start = 1'b0;
   endtask
   task automatic wait_done(input int budget);
      int k = 0;
      while (done !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("done_within_budget", 64'(done), 64'd1);
      @(negedge clk);
   endtask
   task automatic snap();
      s0 = n_start;
      d0 = n_done;
      r0 = n_res;
   endtask
   // engine model: answers each eng_start after lat[prn] cycles unless that bin is silent
   initial begin
      int p, b;
      eng_done = 1'b0;
      eng_peak = '0;
      eng_phase = '0;
      forever begin
         @(negedge clk);
         eng_done = 1'b0;
         if (eng_start === 1'b1) begin
            p = int'(eng_prn);
            b = int'(eng_bin);
            repeat (lat[p]) @(negedge clk);
            if (!silent[p][b]) begin
               eng_done = 1'b1;
               eng_peak = tbl[p][b];
               eng_phase = ph(p, b);
            end
         end
      end
   end
   initial begin
      forever begin
         @(negedge clk);
         if (eng_start === 1'b1) n_start++;
         if (done === 1'b1) n_done++;
         if (res_valid === 1'b1) begin
            n_res++;
            if (exp_q.size() == 0) check("res_queue_nonempty", 64'(exp_q.size()), 64'd1);
            else begin
               got = exp_q.pop_front();
               check("res_fields", 64'({res_prn, res_bin, res_phase, res_peak}), 64'(got));
            end
         end
      end
   end
   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; sat_mask = '0; threshold = '0;
      for (int i = 0; i < 4; i++) begin
         lat[i] = 2;
         for (int j = 0; j < 3; j++) begin
            tbl[i][j] = '0;
            silent[i][j] = 1'b0;
         end
      end
      repeat (3) @(negedge clk);
      check("reset_ctrl", 64'({busy, done, eng_start, res_valid, timeout_err, detected_sat, eng_prn, eng_bin}), 64'd0);
      check("reset_res", 64'({res_prn, res_bin, res_phase, res_peak}), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      // full sweep over PRN0 and PRN2
      tbl[0] = '{50, 120, 90};
      tbl[2] = '{10, 20, 30};
      snap();
      exp_q.push_back(mk(0, 1, 120));
      do_start(4'b0101, 100);
      check("t1_busy", 64'(busy), 64'd1);
      wait_done(400);
      check("t1_eng_starts", 64'(n_start - s0), 64'd6);
      check("t1_reports", 64'(n_res - r0), 64'd1);
      check("t1_done_pulses", 64'(n_done - d0), 64'd1);
      check("t1_detected", 64'(detected_sat), 64'b0001);
      check("t1_timeout_err", 64'(timeout_err), 64'd0);
      check("t1_queue_empty", 64'(exp_q.size()), 64'd0);
      // tie plus peak equal to threshold
      tbl[1] = '{100, 100, 40};
      snap();
      exp_q.push_back(mk(1, 0, 100));
      do_start(4'b0010, 100);
      wait_done(400);
      check("t2_detected", 64'(detected_sat), 64'b0010);
      check("t2_reports", 64'(n_res - r0), 64'd1);
      check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
      // silent engine on PRN1 bin 2, sweep continues into PRN3
      tbl[1] = '{5, 7, 999};
      silent[1][2] = 1'b1;
      tbl[3] = '{200, 1, 1};
      snap();
      exp_q.push_back(mk(3, 0, 200));
      do_start(4'b1010, 100);
      wait_done(600);
      silent[1][2] = 1'b0;
      check("t3_timeout_err", 64'(timeout_err), 64'd1);
      check("t3_done_pulses", 64'(n_done - d0), 64'd1);
      check("t3_eng_starts", 64'(n_start - s0), 64'd6);
      check("t3_detected", 64'(detected_sat), 64'b1000);
      check("t3_queue_empty", 64'(exp_q.size()), 64'd0);
      // empty mask: busy four cycles, done on the fifth
      snap();
      do_start(4'b0000, 0);
      check("t4_busy_k1", 64'(busy), 64'd1);
      check("t4_cleared", 64'({timeout_err, detected_sat}), 64'd0);
      for (int k = 2; k <= 6; k++) begin
         @(negedge clk);
         check($sformatf("t4_busy_k%0d", k), 64'(busy), 64'(k <= 4));
         check($sformatf("t4_done_k%0d", k), 64'(done), 64'(k == 5));
      end
      check("t4_eng_starts", 64'(n_start - s0), 64'd0);
      // abort while waiting on PRN1, late engine answer must be ignored
      tbl[0] = '{150, 1, 1};
      tbl[1] = '{300, 300, 300};
      lat[1] = 15;
      snap();
      exp_q.push_back(mk(0, 0, 150));
      do_start(4'b0011, 100);
      for (int k = 0; k < 200 && !(eng_start === 1'b1 && eng_prn == 5'd1); k++) @(negedge clk);
      check("t5_prn1_launch", 64'({eng_start, eng_prn}), 64'h21);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t5_abort_outs", 64'({busy, done, res_valid, eng_start}), 64'd0);
      repeat (20) @(negedge clk);
      check("t5_idle_after_late", 64'(busy), 64'd0);
      check("t5_detected_kept", 64'(detected_sat), 64'b0001);
      check("t5_no_done", 64'(n_done - d0), 64'd0);
      check("t5_reports", 64'(n_res - r0), 64'd1);
      lat[1] = 2;
      do_start(4'b0000, 0);
      check("t5_restart_clears", 64'(detected_sat), 64'd0);
      wait_done(50);
      // start while busy is dropped
      tbl[0] = '{10, 20, 30};
      snap();
      do_start(4'b0001, 100);
      repeat (3) @(negedge clk);
      start = 1'b1; sat_mask = 4'b1111; threshold = 0;
      @(negedge clk);
      start = 1'b0;
      check("t6_prn_unchanged", 64'({busy, eng_prn}), 64'h20);
      wait_done(400);
      check("t6_eng_starts", 64'(n_start - s0), 64'd3);
      check("t6_reports", 64'(n_res - r0), 64'd0);
      check("t6_detected", 64'(detected_sat), 64'd0);
      // reset in the middle of a search
      tbl[1] = '{1, 2, 3};
      exp_q.push_back(mk(0, 2, 30));
      do_start(4'b1111, 0);
      for (int k = 0; k < 200 && res_valid !== 1'b1; k++) @(negedge clk);
      check("t7_report_seen", 64'(res_valid), 64'd1);
      repeat (3) @(negedge clk);
      check("t7_busy_before_reset", 64'({busy, detected_sat}), 64'h11);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t7_reset_ctrl", 64'({busy, done, eng_start, res_valid, timeout_err, detected_sat, eng_prn, eng_bin}), 64'd0);
      check("t7_reset_res", 64'({res_prn, res_bin, res_phase, res_peak}), 64'd0);
      repeat (20) @(negedge clk);
      check("t7_stays_idle", 64'(busy), 64'd0);
      check("t7_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
